// File: rtl/calc2_port_responder.sv
// calc2_port_responder: single-port calc2 request/response engine.
// Captures two-cycle requests, queues them in order, executes each on a
// fixed-latency ALU and returns a tagged one-cycle response.
// Optional feature macro: CALC2_SHIFT_EN (compiles in the shl/shr datapath;
// when undefined, cmds 5/6 respond as invalid at the same latency).
module calc2_port_responder #(
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    input  logic [1:0]  req_tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag,
    output logic        req_drop
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 4 + 32 + 32 + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAT_CNT  = 4'(LAT);

    typedef enum logic { CAP_IDLE, CAP_OP2 } cap_state_t;
    typedef enum logic { EX_IDLE, EX_BUSY } ex_state_t;

    // Result of one ALU operation: {resp[1:0], data[31:0]}; data is zero
    // whenever resp is not success.
    function automatic logic [33:0] alu_op(input logic [3:0] cmd,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] sum;
        logic [1:0]  resp;
        logic [31:0] res;
        resp = 2'b10;
        res  = '0;
        sum  = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1: begin
                if (!sum[32]) begin
                    resp = 2'b01;
                    res  = sum[31:0];
                end
            end
            4'd2: begin
                if (a >= b) begin
                    resp = 2'b01;
                    res  = a - b;
                end
            end
`ifdef CALC2_SHIFT_EN
            4'd5: begin
                resp = 2'b01;
                res  = a << b[4:0];
            end
            4'd6: begin
                resp = 2'b01;
                res  = a >> b[4:0];
            end
`endif
            default: begin
                resp = 2'b10;
                res  = '0;
            end
        endcase
        return {resp, res};
    endfunction

    cap_state_t       r_cap_state, w_cap_next;
    ex_state_t        r_ex_state, w_ex_next;
    logic [3:0]       r_cmd;
    logic [31:0]      r_op1;
    logic [1:0]       r_tag;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic [EW-1:0]    r_ex_entry;
    logic [3:0]       r_cnt;
    logic             w_push, w_push_ok, w_pop, w_full, w_empty, w_fire;
    logic [EW-1:0]    w_push_entry;
    logic [33:0]      w_alu;

    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_pop        = (r_ex_state == EX_IDLE) && !w_empty;
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_push_entry = {r_cmd, r_op1, req_data_in, r_tag};
    assign w_alu        = alu_op(r_ex_entry[69:66], r_ex_entry[65:34], r_ex_entry[33:2]);

    // Capture FSM state register.
    always_ff @(posedge c_clk) begin
        if (reset) r_cap_state <= CAP_IDLE;
        else       r_cap_state <= w_cap_next;
    end

    // Capture FSM next state: command cycle, then operand-2 cycle pushes.
    always_comb begin
        w_cap_next = r_cap_state;
        w_push     = 1'b0;
        case (r_cap_state)
            CAP_IDLE: if (req_cmd_in != 4'd0) w_cap_next = CAP_OP2;
            CAP_OP2: begin
                w_push     = 1'b1;
                w_cap_next = CAP_IDLE;
            end
            default: w_cap_next = CAP_IDLE;
        endcase
    end

    // Command-cycle fields held until the operand-2 cycle.
    always_ff @(posedge c_clk) begin
        if (r_cap_state == CAP_IDLE && req_cmd_in != 4'd0) begin
            r_cmd <= req_cmd_in;
            r_op1 <= req_data_in;
            r_tag <= req_tag_in;
        end
    end

    // Queue storage; a full queue still accepts when a pop frees a slot.
    always_ff @(posedge c_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_entry;
    end

    // Queue pointers, occupancy and drop pulse.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            req_drop <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            req_drop <= w_push && w_full && !w_pop;
        end
    end

    // Executor FSM state register.
    always_ff @(posedge c_clk) begin
        if (reset) r_ex_state <= EX_IDLE;
        else       r_ex_state <= w_ex_next;
    end

    // Executor next state: pop when idle, fire when the countdown expires.
    always_comb begin
        w_ex_next = r_ex_state;
        w_fire    = 1'b0;
        case (r_ex_state)
            EX_IDLE: if (!w_empty) w_ex_next = EX_BUSY;
            EX_BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_fire    = 1'b1;
                    w_ex_next = EX_IDLE;
                end
            end
            default: w_ex_next = EX_IDLE;
        endcase
    end

    // Latency down-counter, loaded on pop.
    always_ff @(posedge c_clk) begin
        if (reset)                     r_cnt <= '0;
        else if (w_pop)                r_cnt <= LAT_CNT;
        else if (r_ex_state == EX_BUSY) r_cnt <= r_cnt - 1'b1;
    end

    // Entry under execution.
    always_ff @(posedge c_clk) begin
        if (w_pop) r_ex_entry <= r_mem[r_rd_ptr];
    end

    // One-cycle response register; idles at zero.
    always_ff @(posedge c_clk) begin
        if (reset || !w_fire) begin
            out_resp <= 2'b00;
            out_data <= '0;
            out_tag  <= 2'b00;
        end else begin
            out_resp <= w_alu[33:32];
            out_data <= w_alu[31:0];
            out_tag  <= r_ex_entry[1:0];
        end
    end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: instance A (LAT=2) covers the
// arithmetic and reset cases, instance B (LAT=15) covers queue overflow.
module tb_calc2_port_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 15;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [3:0]  a_cmd, b_cmd;
    logic [31:0] a_din, b_din;
    logic [1:0]  a_tin, b_tin;
    logic [1:0]  a_resp, b_resp;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_tag, b_tag;
    logic        a_drop, b_drop;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   qdrop[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    calc2_port_responder #(.LAT(LAT_A), .FIFO_DEPTH(4)) dut_a (
        .c_clk(clk), .reset(rst_a), .req_cmd_in(a_cmd), .req_data_in(a_din),
        .req_tag_in(a_tin), .out_resp(a_resp), .out_data(a_data),
        .out_tag(a_tag), .req_drop(a_drop));

    calc2_port_responder #(.LAT(LAT_B), .FIFO_DEPTH(4)) dut_b (
        .c_clk(clk), .reset(rst_b), .req_cmd_in(b_cmd), .req_data_in(b_din),
        .req_tag_in(b_tin), .out_resp(b_resp), .out_data(b_data),
        .out_tag(b_tag), .req_drop(b_drop));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp_resp(input string nm, input logic [1:0] r, input logic [31:0] d,
                            input logic [1:0] t, input exp_t e);
        checks++;
        if (r !== e.resp || d !== e.data || t !== e.tag || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s: got resp=%0d data=%h tag=%0d cyc=%0d, required resp=%0d data=%h tag=%0d cyc=%0d",
                     nm, r, d, t, cyc, e.resp, e.data, e.tag, e.cyc);
        end
    endtask

    task automatic chk_zero(input string nm, input logic [1:0] r, input logic [31:0] d,
                            input logic [1:0] t, input logic dr);
        checks++;
        if (r !== 2'b00 || d !== 32'h0 || t !== 2'b00 || dr !== 1'b0) begin
            errors++;
            $display("FAIL %s: got resp=%0d data=%h tag=%0d drop=%0d, required all zero",
                     nm, r, d, t, dr);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // Monitor: compare every presented response against the scoreboards.
    always @(negedge clk) begin
        exp_t e;
        if (a_resp != 2'b00) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got resp=%0d tag=%0d cyc=%0d, required none", a_resp, a_tag, cyc);
            end else begin
                e = qa.pop_front();
                cmp_resp("a_resp", a_resp, a_data, a_tag, e);
            end
        end else if (a_data !== 32'h0 || a_tag !== 2'b00) begin
            checks++; errors++;
            $display("FAIL a_idle: got data=%h tag=%0d, required 0 while resp=0", a_data, a_tag);
        end
        if (b_resp != 2'b00) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got resp=%0d tag=%0d cyc=%0d, required none", b_resp, b_tag, cyc);
            end else begin
                e = qb.pop_front();
                cmp_resp("b_resp", b_resp, b_data, b_tag, e);
            end
        end
        if (a_drop) begin
            checks++; errors++;
            $display("FAIL a_drop: got 1 at cyc=%0d, required 0", cyc);
        end
        if (b_drop) begin
            if (qdrop.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_drop_unexpected: got pulse at cyc=%0d, required none", cyc);
            end else begin
                chk_int("b_drop_cyc", cyc, qdrop.pop_front());
            end
        end
    end

    // Two-cycle request on instance A with its expected response.
    task automatic send_a(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [1:0] tag, input logic [1:0] er, input logic [31:0] ed);
        exp_t e;
        @(negedge clk);
        a_cmd = cmd; a_din = op1; a_tin = tag;
        @(negedge clk);
        a_cmd = 4'd0; a_din = op2; a_tin = 2'd0;
        e.resp = er; e.data = ed; e.tag = tag; e.cyc = cyc + 2 + LAT_A;
        qa.push_back(e);
        @(negedge clk);
        a_din = 32'h0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   e0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_cmd = 4'd0; a_din = 32'h0; a_tin = 2'd0;
        b_cmd = 4'd0; b_din = 32'h0; b_tin = 2'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset_a", a_resp, a_data, a_tag, a_drop);
        chk_zero("reset_b", b_resp, b_data, b_tag, b_drop);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("post_reset_a", a_resp, a_data, a_tag, a_drop);

        send_a(4'd1, 32'h30, 32'h20, 2'd1, 2'b01, 32'h50);
        send_a(4'd1, 32'hFFFFFFFF, 32'h1, 2'd2, 2'b10, 32'h0);
        send_a(4'd1, 32'h7FFFFFFF, 32'h1, 2'd0, 2'b01, 32'h80000000);
        send_a(4'd2, 32'h10, 32'h20, 2'd3, 2'b10, 32'h0);
        send_a(4'd2, 32'h20, 32'h10, 2'd1, 2'b01, 32'h10);
        send_a(4'd9, 32'h5, 32'h6, 2'd2, 2'b10, 32'h0);
`ifdef CALC2_SHIFT_EN
        send_a(4'd5, 32'h1, 32'h24, 2'd0, 2'b01, 32'h10);
        send_a(4'd6, 32'h80000000, 32'd31, 2'd3, 2'b01, 32'h1);
`else
        send_a(4'd5, 32'h1, 32'h24, 2'd0, 2'b10, 32'h0);
        send_a(4'd6, 32'h80000000, 32'd31, 2'd3, 2'b10, 32'h0);
`endif

        // Reset on the operand-2 edge: request must vanish.
        @(negedge clk);
        a_cmd = 4'd1; a_din = 32'h5; a_tin = 2'd1;
        @(negedge clk);
        a_cmd = 4'd0; a_din = 32'h7; rst_a = 1'b1;
        @(negedge clk);
        chk_zero("rst_op2_during", a_resp, a_data, a_tag, a_drop);
        rst_a = 1'b0;
        repeat (8) @(negedge clk);
        chk_zero("rst_op2_after", a_resp, a_data, a_tag, a_drop);

        // Reset while the executor is busy.
        @(negedge clk);
        a_cmd = 4'd1; a_din = 32'h5; a_tin = 2'd2;
        @(negedge clk);
        a_cmd = 4'd0; a_din = 32'h7;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk_zero("rst_busy_during", a_resp, a_data, a_tag, a_drop);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (8) @(negedge clk);
        chk_zero("rst_busy_after", a_resp, a_data, a_tag, a_drop);
        send_a(4'd1, 32'h1, 32'h1, 2'd3, 2'b01, 32'h2);

        // Held cmd on instance B: seven back-to-back requests into a depth-4 queue.
        e0 = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            b_cmd = 4'd1; b_din = 32'h100 + k; b_tin = 2'(k);
            @(negedge clk);
            b_din = 32'h1;
            if (k == 0) e0 = cyc + 1;
            if (k < 5) begin
                e.resp = 2'b01; e.data = 32'h101 + k; e.tag = 2'(k);
                e.cyc = e0 + 16 + 16 * k;
                qb.push_back(e);
            end else begin
                qdrop.push_back(e0 + 2 * k);
            end
        end
        @(negedge clk);
        b_cmd = 4'd0; b_din = 32'h0; b_tin = 2'd0;
        repeat (110) @(negedge clk);

        chk_int("a_pending", qa.size(), 0);
        chk_int("b_pending", qb.size(), 0);
        chk_int("drop_pending", qdrop.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc2_port_responder.md
# calc2_port_responder

Single-port responder for the calc2 request/response protocol. It accepts two-cycle requests (command, operand 1 and tag, then operand 2), buffers them in an in-order queue, and executes them on a fixed-latency ALU. Each result goes back as a one-cycle response carrying the request's tag. It serves as the port engine behind each calc2 request channel and as a standalone protocol responder for initiator-side benches.

## Interface
- `LAT`, 2: ALU latency in cycles, range 1..15.
- `FIFO_DEPTH`, 4: request queue entries; power of two, ≥2.

- `c_clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_cmd_in`  in  4  command; 0 = no-op, 1 add, 2 sub, 5 shl, 6 shr.
- `req_data_in`  in  32  operand 1 in the command cycle, operand 2 in the next cycle.
- `req_tag_in`  in  2  tag, sampled in the command cycle only.
- `out_resp`  out  2  00 none, 01 success, 10 overflow/underflow/invalid; 11 never driven.
- `out_data`  out  32  result; 0 whenever `out_resp` ≠ 01.
- `out_tag`  out  2  tag of the responding request.
- `req_drop`  out  1  one-cycle pulse: a completed request was discarded because the queue was full.

## Operation
- Capture FSM, IDLE→OP2→IDLE:
  - IDLE: an edge with `req_cmd_in`≠0 latches cmd, operand 1 and tag, then moves to OP2.
  - OP2: the next edge latches operand 2 and pushes {cmd, op1, op2, tag}, then returns to IDLE.
  - `req_cmd_in` and `req_tag_in` are ignored in OP2.
  - A request can therefore start at the edge after the OP2 edge, so a held nonzero cmd issues a new request every 2 cycles.
- Queue: FIFO of depth `FIFO_DEPTH`.
  - A push when full is discarded and pulses `req_drop` for the cycle after that edge.
  - A push and pop on the same edge while full is accepted; the pop is evaluated first.
- Executor FSM, IDLE→BUSY→IDLE:
  - IDLE with the queue non-empty pops one entry and loads a down-counter with `LAT`.
  - BUSY decrements the counter; at 0 it registers the response and returns to IDLE.
  - It can pop the next entry on the following edge.
- Arithmetic, all 32-bit unsigned:
  - add: 33-bit sum; carry out → resp 10, data 0; otherwise resp 01, sum.
  - sub: op1<op2 → resp 10, data 0; otherwise resp 01, op1−op2.
  - shl/shr: logical shift of op1 by op2[4:0]; resp 01.
  - Any other nonzero cmd: resp 10, data 0.
- Responses leave in request order, one per executed entry.

## Timing
- The response is valid for exactly one cycle, then `out_resp`/`out_data`/`out_tag` return to 0.
- Empty queue, executor idle, operand-2 edge E:
  - pop at E+1;
  - response registered at E+1+`LAT`, i.e. visible in the cycle after that edge.
  - With `LAT`=2, the response is visible after edge E+3.
- Sustained throughput is one response per `LAT`+1 cycles. Arrivals are at most one per 2 cycles, so the queue fills only when `LAT`≥2.
- Reset:
  - Reset values: `out_resp`=0, `out_data`=0, `out_tag`=0, `req_drop`=0.
  - Both FSMs return to IDLE, the queue empties and the counter clears.
  - Reset mid-request (including in OP2) or mid-execution discards all in-flight work; no response is produced for it.
  - Inputs are sampled normally from the first edge with `reset`=0.

## Configuration
- `CALC2_SHIFT_EN`:
  - Defined: cmds 5/6 execute as shl/shr as above.
  - Undefined: the shifter is not compiled in. Cmds 5/6 are captured and queued like any request, and respond 10 with data 0 at identical latency.

## Test plan
- Add op1 0x30, op2 0x20, tag 1, `LAT`=2 → after edge E+3: resp 01, data 0x00000050, tag 1, for one cycle only; then all zero.
- Add 0xFFFFFFFF + 0x1, tag 2 → resp 10, data 0, tag 2. Add 0x7FFFFFFF + 0x1 → resp 01, data 0x80000000.
- Sub 0x10−0x20, tag 3 → resp 10, data 0. Sub 0x20−0x10 → resp 01, data 0x10. Invalid cmd 0x9 → resp 10, data 0.
- Shl 0x1 by 0x24 → 0x10 (low 5 bits used). Shr 0x80000000 by 31 → 0x1. With `CALC2_SHIFT_EN` undefined, both → resp 10, data 0.
- `LAT`=15, `FIFO_DEPTH`=4, cmd held at 1 for 7 requests, tags 0,1,2,3,0,1,2 → the 6th and 7th pushes each pulse `req_drop`. Exactly 5 responses follow, in order (tags 0,1,2,3,0), spaced 16 cycles apart.
- Reset asserted on the OP2 edge of an add, and again during BUSY, → no response; all outputs 0 during and after reset. A following fresh add 1+1 → resp 01, data 2.
